// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcode
// constants, immediate-format selects (numerically identical to the
// sign-extend unit's select input), FSM state type and datapath mux codes.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_NONE  = 3'b000;
  localparam logic [2:0] IMM_U     = 3'b001;
  localparam logic [2:0] IMM_I     = 3'b010;
  localparam logic [2:0] IMM_SHAMT = 3'b011;
  localparam logic [2:0] IMM_B     = 3'b100;
  localparam logic [2:0] IMM_S     = 3'b101;
  localparam logic [2:0] IMM_J     = 3'b110;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_FUNCT = 2'd1;
  localparam logic [1:0] ALU_PASSB = 2'd2;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_imm_sel_dec.sv
// Pure opcode/funct3 -> immediate-format decoder.
// Ports: i_opcode (instr[6:0]), i_funct3 (instr[14:12]),
//        o_imm_sel (format select for the sign-extend unit).
module rv_imm_sel_dec
  import rv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output logic [2:0] o_imm_sel
);

  always_comb begin
    o_imm_sel = IMM_NONE;
    case (i_opcode)
      OPC_LUI, OPC_AUIPC: o_imm_sel = IMM_U;
      OPC_JAL:            o_imm_sel = IMM_J;
      OPC_JALR, OPC_LOAD: o_imm_sel = IMM_I;
      OPC_BRANCH:         o_imm_sel = IMM_B;
      OPC_STORE:          o_imm_sel = IMM_S;
      // SLLI/SRLI/SRAI carry a shift amount, not a full I immediate
      OPC_OPIMM:          o_imm_sel = (i_funct3 == 3'b001 || i_funct3 == 3'b101)
                                      ? IMM_SHAMT : IMM_I;
      default:            o_imm_sel = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/rv_mc_control.sv
// Multi-cycle RV32I control FSM sequencing PC, IR, register file, ALU,
// shared memory port and immediate unit.
// Inputs : clk, rst (sync, active-high), opcode/funct3 from the IR,
//          br_taken from the branch comparator, mem_ready from memory.
// Outputs: mem_req/mem_we/addr_sel (memory port), ir_we, pc_we/pc_sel,
//          rf_we/wb_sel, alu_a_sel/alu_b_sel/alu_op, imm_sel,
//          retire (per-instruction pulse), illegal (sticky trap).
module rv_mc_control
  import rv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       retire,
  output logic       illegal
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_wait;
  logic [2:0]  w_imm_sel;
  logic        w_waiting;
  logic        w_timeout;

  rv_imm_sel_dec u_imm_dec (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .o_imm_sel (w_imm_sel)
  );

  assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_wait == MEM_TIMEOUT - 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:  if (mem_ready) w_next = ST_DECODE;
                 else if (w_timeout) w_next = ST_TRAP;
      ST_DECODE: w_next = is_legal(opcode) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (opcode)
          OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: w_next = ST_WB;
          OPC_LOAD, OPC_STORE:                   w_next = ST_MEM;
          OPC_JAL, OPC_JALR, OPC_BRANCH:         w_next = ST_FETCH;
          default:                               w_next = ST_TRAP;
        endcase
      end
      ST_MEM:    if (mem_ready) w_next = (opcode == OPC_STORE) ? ST_FETCH : ST_WB;
                 else if (w_timeout) w_next = ST_TRAP;
      ST_WB:     w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_FETCH;
    endcase
  end

  // Counter only runs while stalled in FETCH/MEM, so it is zero on entry
  // to either state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_waiting ? r_wait + 32'd1 : '0;
    end
  end

  // rst gates the decode directly so an in-flight access drops in the
  // same cycle reset is seen, before the state register is cleared.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    alu_op    = ALU_ADD;
    imm_sel   = IMM_NONE;
    retire    = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        ST_EXEC: begin
          imm_sel = w_imm_sel;
          case (opcode)
            OPC_LUI:   begin alu_a_sel = A_ZERO; alu_b_sel = B_IMM; end
            OPC_AUIPC: begin alu_a_sel = A_PC;   alu_b_sel = B_IMM; end
            OPC_JAL: begin
              pc_we = 1'b1; pc_sel = PC_BRANCH;
              rf_we = 1'b1; wb_sel = WB_LINK; retire = 1'b1;
            end
            OPC_JALR: begin
              alu_b_sel = B_IMM;
              pc_we = 1'b1; pc_sel = PC_JALR;
              rf_we = 1'b1; wb_sel = WB_LINK; retire = 1'b1;
            end
            OPC_BRANCH: begin
              pc_we = br_taken; pc_sel = PC_BRANCH; retire = 1'b1;
            end
            OPC_LOAD, OPC_STORE: alu_b_sel = B_IMM;
            OPC_OPIMM: begin alu_b_sel = B_IMM; alu_op = ALU_FUNCT; end
            OPC_OP:    begin alu_b_sel = B_RS2; alu_op = ALU_FUNCT; end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (opcode == OPC_STORE);
          retire   = (opcode == OPC_STORE) && mem_ready;
        end
        ST_WB: begin
          rf_we  = 1'b1;
          retire = 1'b1;
          wb_sel = (opcode == OPC_LOAD) ? WB_MEM : WB_ALU;
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mc_control.sv
module tb_rv_mc_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [1:0] op;
    logic [2:0] imm;
    logic       retire;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, alu_b_sel, retire, illegal;
  logic [1:0] pc_sel, wb_sel, alu_a_sel, alu_op;
  logic [2:0] imm_sel;
  outs_t      w_obs;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  outs_t sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  rv_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .imm_sel(imm_sel), .retire(retire), .illegal(illegal)
  );

  assign w_obs = '{mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                   alu_a_sel, alu_b_sel, alu_op, imm_sel, retire, illegal};

  // Queue the expectation for the current cycle, compare at the falling
  // edge, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input outs_t e);
    outs_t x;
    string t;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert (w_obs === x) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", t, w_obs, x);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t f_fetch(input logic rdy);
    outs_t o = '0;
    o.mem_req = 1'b1;
    o.ir_we   = rdy;
    o.pc_we   = rdy;
    return o;
  endfunction

  function automatic outs_t f_exec(input logic [2:0] imm, input logic [1:0] a,
                                   input logic b, input logic [1:0] op);
    outs_t o = '0;
    o.imm = imm; o.a_sel = a; o.b_sel = b; o.op = op;
    return o;
  endfunction

  function automatic outs_t f_mem(input logic st, input logic rdy);
    outs_t o = '0;
    o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = st; o.retire = st & rdy;
    return o;
  endfunction

  function automatic outs_t f_wb(input logic ld);
    outs_t o = '0;
    o.rf_we = 1'b1; o.retire = 1'b1; o.wb_sel = ld ? 2'd1 : 2'd0;
    return o;
  endfunction

  task automatic start(input logic [6:0] opc, input logic [2:0] f3);
    opcode = opc; funct3 = f3; mem_ready = 1'b1;
    cyc("fetch", f_fetch(1'b1));
    cyc("decode", '0);
  endtask

  outs_t e;

  initial begin
    @(posedge clk); #1;
    // Reset held three cycles: nothing asserted.
    for (int i = 0; i < 3; i++) cyc("reset", '0);
    rst = 1'b0;

    // ADDI, then SLLI
    start(7'b0010011, 3'b000);
    cyc("addi_exec", f_exec(3'b010, 2'd0, 1'b1, 2'd1));
    cyc("addi_wb", f_wb(1'b0));
    start(7'b0010011, 3'b001);
    cyc("slli_exec", f_exec(3'b011, 2'd0, 1'b1, 2'd1));
    cyc("slli_wb", f_wb(1'b0));

    // LW with three wait cycles in MEM
    start(7'b0000011, 3'b010);
    cyc("lw_exec", f_exec(3'b010, 2'd0, 1'b1, 2'd0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", f_mem(1'b0, 1'b0));
    mem_ready = 1'b1;
    cyc("lw_mem_rdy", f_mem(1'b0, 1'b1));
    cyc("lw_wb", f_wb(1'b1));

    // SW
    start(7'b0100011, 3'b010);
    cyc("sw_exec", f_exec(3'b101, 2'd0, 1'b1, 2'd0));
    cyc("sw_mem", f_mem(1'b1, 1'b1));

    // BEQ not taken / taken
    start(7'b1100011, 3'b000);
    br_taken = 1'b0;
    e = f_exec(3'b100, 2'd0, 1'b0, 2'd0); e.pc_sel = 2'd1; e.retire = 1'b1;
    cyc("beq_nt", e);
    start(7'b1100011, 3'b000);
    br_taken = 1'b1;
    e.pc_we = 1'b1;
    cyc("beq_t", e);
    br_taken = 1'b0;

    // JAL
    start(7'b1101111, 3'b000);
    e = f_exec(3'b110, 2'd0, 1'b0, 2'd0);
    e.pc_we = 1'b1; e.pc_sel = 2'd1; e.rf_we = 1'b1; e.wb_sel = 2'd2; e.retire = 1'b1;
    cyc("jal_exec", e);

    // JALR
    start(7'b1100111, 3'b000);
    e = f_exec(3'b010, 2'd0, 1'b1, 2'd0);
    e.pc_we = 1'b1; e.pc_sel = 2'd2; e.rf_we = 1'b1; e.wb_sel = 2'd2; e.retire = 1'b1;
    cyc("jalr_exec", e);

    // LUI, AUIPC
    start(7'b0110111, 3'b000);
    cyc("lui_exec", f_exec(3'b001, 2'd2, 1'b1, 2'd0));
    cyc("lui_wb", f_wb(1'b0));
    start(7'b0010111, 3'b000);
    cyc("auipc_exec", f_exec(3'b001, 2'd1, 1'b1, 2'd0));
    cyc("auipc_wb", f_wb(1'b0));

    // OP with two fetch wait cycles
    opcode = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b0;
    cyc("fetch_wait", f_fetch(1'b0));
    cyc("fetch_wait", f_fetch(1'b0));
    mem_ready = 1'b1;
    cyc("op_fetch", f_fetch(1'b1));
    cyc("op_decode", '0);
    cyc("op_exec", f_exec(3'b000, 2'd0, 1'b0, 2'd1));
    cyc("op_wb", f_wb(1'b0));

    // Reset in the middle of a load's MEM wait
    start(7'b0000011, 3'b010);
    cyc("lw2_exec", f_exec(3'b010, 2'd0, 1'b1, 2'd0));
    mem_ready = 1'b0;
    cyc("lw2_mem_wait", f_mem(1'b0, 1'b0));
    rst = 1'b1; mem_ready = 1'b1;
    cyc("rst_mid_mem", '0);
    cyc("rst_mid_mem", '0);
    rst = 1'b0;
    start(7'b0010011, 3'b000);
    cyc("restart_exec", f_exec(3'b010, 2'd0, 1'b1, 2'd1));
    cyc("restart_wb", f_wb(1'b0));

    // Illegal opcode -> sticky TRAP
    start(7'b1111111, 3'b000);
    e = '0; e.illegal = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      cyc("trap", e);
    end
    rst = 1'b1;
    cyc("trap_rst", '0);
    rst = 1'b0; mem_ready = 1'b1;
    cyc("post_trap_fetch", f_fetch(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_mc_control.md
Name: rv_mc_control

Overview:
- Multi-cycle RV32I control FSM that sequences the shared datapath: PC, instruction register, register file, ALU, memory port and the immediate sign-extend unit.
- Decodes the latched instruction's opcode/funct fields.
- Drives the 3-bit immediate-format select and all write strobes and muxes for each phase.
- Handshakes with a single shared instruction/data memory port and flags illegal opcodes.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait for mem_ready before trapping; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- br_taken  in  1  branch comparator result for current funct3/rs1/rs2
- mem_ready  in  1  memory accepted write / returned read data this cycle
- mem_req  out  1  memory request
- mem_we  out  1  request is a store
- addr_sel  out  1  0 = PC, 1 = ALU result register
- ir_we  out  1  load instruction register, and capture old PC
- pc_we  out  1  PC write strobe
- pc_sel  out  2  0 = PC+4, 1 = oldPC+imm, 2 = (rs1+imm)&~1
- rf_we  out  1  register-file write
- wb_sel  out  2  0 = ALU result, 1 = memory data, 2 = oldPC+4
- alu_a_sel  out  2  0 = rs1, 1 = oldPC, 2 = zero
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  0 = ADD, 1 = decode funct3/funct7, 2 = pass B
- imm_sel  out  3  immediate format
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  sticky trap flag

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- All outputs are decoded from state plus the latched opcode.
- Reset:
  - While rst=1, state is FETCH, illegal=0 and every strobe is forced to 0.
  - The first request issues the cycle after rst falls.
  - Reset mid-MEM or mid-FETCH aborts the access: mem_req drops and nothing is written.
- imm_sel encoding: 000 none, 001 U, 010 I/load/JALR, 011 shift-amount, 100 B, 101 S, 110 J.
- FETCH:
  - mem_req=1, addr_sel=0.
  - Hold until mem_ready=1; mem_req never deasserts while waiting.
  - On mem_ready: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
- DECODE:
  - One cycle; register operands latched.
  - Unknown opcode goes to TRAP; otherwise EXEC.
- EXEC, per opcode:
  - LUI 0110111: imm 001, a=zero, b=imm, op=ADD; then WB.
  - AUIPC 0010111: imm 001, a=oldPC, b=imm, op=ADD; then WB.
  - JAL 1101111: imm 110, pc_we, pc_sel=1, rf_we, wb_sel=2, retire; then FETCH.
  - JALR 1100111: imm 010, a=rs1, b=imm, pc_we, pc_sel=2, rf_we, wb_sel=2, retire; then FETCH.
  - BRANCH 1100011: imm 100; pc_we=br_taken with pc_sel=1; retire; then FETCH.
  - LOAD 0000011 / STORE 0100011: imm 010 / 101, a=rs1, b=imm, op=ADD; then MEM.
  - OP-IMM 0010011: imm 011 if funct3 is 001 or 101, else 010; b=imm, op=1; then WB.
  - OP 0110011: imm 000, b=rs2, op=1; then WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(STORE).
  - Hold until mem_ready.
  - On mem_ready: a store retires and goes to FETCH; a load goes to WB.
- WB:
  - rf_we=1, retire=1; wb_sel=1 for LOAD, else 0; then FETCH.
- Latencies, assuming zero-wait memory:
  - ALU/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch/JAL/JALR: 3 cycles.
  - Each wait cycle adds 1.
- Timeout: with MEM_TIMEOUT>0, a wait counter clears on entering FETCH/MEM. When it reaches MEM_TIMEOUT without mem_ready, the FSM goes to TRAP.
- TRAP:
  - illegal=1, all strobes 0.
  - Held until rst.
- Outside TRAP, imm_sel is 000 in all states other than EXEC.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants
  - IMM_NONE/U/I/SHAMT/B/S/J codes, numerically matching the sign-extend unit's select
  - state enum
  - pc_sel / wb_sel / alu_*_sel codes
- Natural sub-module: rv_imm_sel_dec, a pure opcode+funct3 to imm_sel decoder, reused by the FSM.

Test Plan:
- rst high 3 cycles, then low, mem_ready=1 -> mem_req=1 first cycle after reset; no strobes asserted during reset.
- ADDI (opcode 0010011, funct3 000), zero-wait -> EXEC imm_sel=010, WB rf_we=1, retire on cycle 4; SLLI (funct3 001) -> imm_sel=011.
- LW with mem_ready low for 3 cycles in MEM -> mem_req held steady for 4 cycles, mem_we=0, then WB wb_sel=1, retire on cycle 8.
- SW -> EXEC imm_sel=101, MEM mem_we=1, no rf_we, retire with mem_ready; BEQ with br_taken=0 -> pc_we=0; with br_taken=1 -> pc_we=1, pc_sel=1, imm_sel=100.
- JAL -> imm_sel=110, pc_sel=1, rf_we=1, wb_sel=2 in cycle 3; LUI -> imm_sel=001, alu_a_sel=2.
- Opcode 1111111 -> TRAP, illegal=1 sticky for 100 cycles, no mem_req; reset asserted mid-MEM of a load -> mem_req=0, rf_we never pulses, restart in FETCH.
